// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, W_DATA data bits, optional parity, N_STOP stop bits.
// One bit per baud_tick period; a word is taken over tx_valid/tx_ready only when idle.
module uart_tx_framer #(
  parameter int W_DATA      = 8,
  parameter int PARITY_MODE = 1,
  parameter int N_STOP      = 1,
  parameter int LSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              tx_valid,
  input  logic [W_DATA-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  localparam logic [3:0] LAST_BIT  = 4'(W_DATA - 1);
  localparam logic [3:0] LAST_STOP = 4'(N_STOP - 1);
  localparam bit         HAS_PAR   = (PARITY_MODE != 0);
  localparam logic       PAR_INV   = (PARITY_MODE == 2);

  if (W_DATA < 5 || W_DATA > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      N_STOP < 1 || N_STOP > 2) begin : g_bad_params
    $error("uart_tx_framer: illegal W_DATA, PARITY_MODE or N_STOP");
  end

  logic [2:0]        state_q, state_d;
  logic [W_DATA-1:0] shreg_q, shreg_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic head_bit(input logic [W_DATA-1:0] v);
    if (LSB_FIRST != 0) return v[0];
    return v[W_DATA-1];
  endfunction

  function automatic logic [W_DATA-1:0] shift_out(input logic [W_DATA-1:0] v);
    if (LSB_FIRST != 0) return {1'b0, v[W_DATA-1:1]};
    return {v[W_DATA-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A tick in the accept cycle is deliberately not looked at here.
        if (tx_valid && tx_ready_q) begin
          shreg_d = tx_data;
          par_d   = (^tx_data) ^ PAR_INV;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (baud_tick) state_d = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shreg_d = shift_out(shreg_q);
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (cnt_q == LAST_STOP) begin
            cnt_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    tx_out_d   = 1'b1;
    tx_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = head_bit(shreg_d);
      S_PARITY: tx_out_d = par_d;
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four parameter sets side by side, a frame-level line model,
// vector table, hand-written corner sequences and a randomized run.
module tb_uart_tx_framer;

  localparam int ND = 4;
  localparam int TP = 4;

  typedef logic [15:0] frame_t;
  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [15:0] bits;
    int          nbits;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          baud_tick = 1'b0;
  logic [ND-1:0] tx_valid = '0;
  logic [7:0]    tx_data [ND];
  logic [ND-1:0] tx_ready, tx_out, busy, frame_done;

  int p_w  [ND] = '{8, 8, 8, 5};
  int p_pm [ND] = '{1, 2, 0, 0};
  int p_ns [ND] = '{1, 1, 1, 2};
  int p_lf [ND] = '{1, 1, 1, 0};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit tick_rand = 1'b0;

  uart_tx_framer #(.W_DATA(8), .PARITY_MODE(1), .N_STOP(1), .LSB_FIRST(1)) u_even (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
    .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .busy(busy[0]), .frame_done(frame_done[0]));
  uart_tx_framer #(.W_DATA(8), .PARITY_MODE(2), .N_STOP(1), .LSB_FIRST(1)) u_odd (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
    .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .busy(busy[1]), .frame_done(frame_done[1]));
  uart_tx_framer #(.W_DATA(8), .PARITY_MODE(0), .N_STOP(1), .LSB_FIRST(1)) u_none (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]),
    .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .busy(busy[2]), .frame_done(frame_done[2]));
  uart_tx_framer #(.W_DATA(5), .PARITY_MODE(0), .N_STOP(2), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[3]), .tx_data(tx_data[3][4:0]),
    .tx_ready(tx_ready[3]), .tx_out(tx_out[3]), .busy(busy[3]), .frame_done(frame_done[3]));

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1 baud_tick = tick_rand ? ($urandom_range(0, 2) == 0) : ((cyc % TP) == 0);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input int i);
    return 1 + p_w[i] + ((p_pm[i] != 0) ? 1 : 0) + p_ns[i];
  endfunction

  // f[k] is the k-th bit on the line; unused tail stays 1 so stop bits come for free.
  function automatic frame_t build_frame(input int i, input logic [7:0] d);
    frame_t f;
    int ones;
    int pos;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int j = 0; j < p_w[i]; j++) begin
      f[1+j] = (p_lf[i] != 0) ? d[j] : d[p_w[i]-1-j];
      ones += int'(d[j]);
    end
    pos = 1 + p_w[i];
    if (p_pm[i] == 1) f[pos] = ones[0];
    else if (p_pm[i] == 2) f[pos] = ~ones[0];
    return f;
  endfunction

  // Line model: after accept, count ticks; tick 1 ends the arm wait, ticks 2..L+1 end frame bits.
  bit     m_act  [ND];
  bit     m_done [ND];
  int     m_k    [ND];
  frame_t m_f    [ND];

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      logic [3:0] e;
      logic [3:0] a;
      logic       eo;
      if (!rst) begin
        m_act[i]  = 1'b0;
        m_done[i] = 1'b0;
      end
      eo = (m_act[i] && m_k[i] > 0) ? m_f[i][m_k[i]-1] : 1'b1;
      e  = {eo, ~m_act[i], m_act[i], m_done[i]};
      a  = {tx_out[i], tx_ready[i], busy[i], frame_done[i]};
      check($sformatf("line_model_dut%0d {out,rdy,busy,done}", i), int'(a), int'(e));
      if (rst) begin
        m_done[i] = 1'b0;
        if (!m_act[i]) begin
          if (tx_valid[i]) begin
            m_act[i] = 1'b1;
            m_k[i]   = 0;
            m_f[i]   = build_frame(i, tx_data[i]);
          end
        end else if (baud_tick) begin
          m_k[i]++;
          if (m_k[i] == frame_len(i) + 1) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int i);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_ready[i] && !busy[i]) break;
    end
    check($sformatf("idle_wait_dut%0d", i), int'(tx_ready[i]), 1);
  endtask

  // Sends one word and records the line value at each tick that ends a frame bit.
  task automatic send_capture(input int i, input logic [7:0] d,
                              output frame_t got, output int n, output bit seen);
    int ticks;
    got = '0;
    n = 0;
    seen = 1'b0;
    ticks = 0;
    wait_idle(i);
    @(posedge clk); #2;
    tx_data[i] = d;
    tx_valid[i] = 1'b1;
    @(posedge clk); #2;
    tx_valid[i] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (frame_done[i]) begin
        seen = 1'b1;
        break;
      end
      if (baud_tick) begin
        if (ticks > 0 && n < 16) begin
          got[n] = tx_out[i];
          n++;
        end
        ticks++;
      end
    end
  endtask

  vec_t   vecs [8];
  frame_t got, exp;
  int     n, hi, lo, ticks, dones;
  bit     seen;

  initial begin
    for (int i = 0; i < ND; i++) tx_data[i] = 8'h00;
    vecs[0] = '{0, 8'hA5, 16'b01010010101, 11};
    vecs[1] = '{1, 8'h07, 16'b01110000001, 11};
    vecs[2] = '{0, 8'h07, 16'b01110000011, 11};
    vecs[3] = '{2, 8'h07, 16'b0111000001, 10};
    vecs[4] = '{3, 8'h10, 16'b01000011, 8};
    vecs[5] = '{0, 8'hFF, 16'b01111111101, 11};
    vecs[6] = '{1, 8'h00, 16'b00000000011, 11};
    vecs[7] = '{3, 8'h05, 16'b00010111, 8};

    repeat (3) @(posedge clk);
    #2;
    check("reset_tx_out", int'(tx_out), 4'hF);
    check("reset_tx_ready", int'(tx_ready), 4'hF);
    check("reset_busy", int'(busy), 0);
    rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      send_capture(vecs[v].dut, vecs[v].data, got, n, seen);
      exp = '0;
      for (int k = 0; k < vecs[v].nbits; k++) exp[k] = vecs[v].bits[vecs[v].nbits-1-k];
      check($sformatf("vec%0d_done_seen", v), int'(seen), 1);
      check($sformatf("vec%0d_len", v), n, vecs[v].nbits);
      check($sformatf("vec%0d_bits", v), int'(got), int'(exp));
      check($sformatf("vec%0d_ready_with_done", v), int'(tx_ready[vecs[v].dut]), 1);
    end

    // Tick coincident with accept: arm wait is a full period, start bit a full period.
    wait_idle(0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (baud_tick) break;
    end
    tx_data[0] = 8'hFF;
    tx_valid[0] = 1'b1;
    @(posedge clk); #2;
    tx_valid[0] = 1'b0;
    hi = 0;
    lo = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_out[0]) begin
        if (lo > 0) break;
        hi++;
      end else begin
        lo++;
      end
    end
    check("coinc_arm_cycles", hi, TP);
    check("coinc_start_cycles", lo, TP);

    // Back-to-back with tx_valid held, data changed after accept, valid pulses while busy.
    wait_idle(0);
    @(posedge clk); #2;
    tx_data[0] = 8'h01;
    tx_valid[0] = 1'b1;
    @(posedge clk); #2;
    tx_data[0] = 8'hFF;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (frame_done[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_first_done", int'(seen), 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (baud_tick) break;
    end
    @(negedge clk);
    check("b2b_second_start", int'(tx_out[0]), 0);
    @(posedge clk); #2;
    tx_valid[0] = 1'b0;
    tx_data[0] = 8'h5A;
    for (int p = 0; p < 3; p++) begin
      repeat (3) @(posedge clk);
      #2 tx_valid[0] = 1'b1;
      @(posedge clk);
      #2 tx_valid[0] = 1'b0;
    end
    dones = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (frame_done[0]) dones++;
    end
    check("b2b_only_one_more_frame", dones, 1);

    // Reset during data bit 3, then a clean frame.
    wait_idle(0);
    @(posedge clk); #2;
    tx_data[0] = 8'hA5;
    tx_valid[0] = 1'b1;
    @(posedge clk); #2;
    tx_valid[0] = 1'b0;
    ticks = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (baud_tick) ticks++;
      if (ticks == 5) break;
    end
    @(posedge clk); #2;
    check("pre_reset_bit3", int'(tx_out[0]), 0);
    rst = 1'b0;
    #1;
    check("rst_tx_out", int'(tx_out[0]), 1);
    check("rst_tx_ready", int'(tx_ready[0]), 1);
    check("rst_busy", int'(busy[0]), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (frame_done[0]) dones++;
    end
    check("rst_no_frame_done", dones, 0);
    send_capture(0, 8'h3C, got, n, seen);
    exp = build_frame(0, 8'h3C);
    for (int k = 11; k < 16; k++) exp[k] = 1'b0;
    check("post_rst_done_seen", int'(seen), 1);
    check("post_rst_len", n, frame_len(0));
    check("post_rst_bits", int'(got), int'(exp));

    // Randomized traffic with irregular ticks and one reset, checked by the line model.
    tick_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < ND; i++) begin
        tx_valid[i] = ($urandom_range(0, 3) == 0);
        tx_data[i]  = 8'($urandom);
      end
      if (c == 1500) rst = 1'b0;
      if (c == 1502) rst = 1'b1;
    end
    tx_valid = '0;
    tick_rand = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
